// File: rtl/heap_chain_ctl.sv
// Build/release sequencer for the linked-memory allocator: builds NIL-terminated chains and frees them.
// Optional pointer tag checking on release is enabled by defining HEAP_CHAIN_CHECK_EN.
module heap_chain_ctl #(
  parameter int DATA_SZ = 16,
  parameter int ADDR_SZ = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cmd_valid,
  input  logic               i_cmd_op,
  input  logic [DATA_SZ-1:0] i_cmd_arg,
  output logic               o_cmd_ready,
  output logic               o_done,
  output logic [DATA_SZ-1:0] o_result,
  output logic               o_fault,
  output logic               o_alloc,
  output logic [DATA_SZ-1:0] o_data,
  output logic               o_free,
  output logic [DATA_SZ-1:0] o_addr,
  output logic               o_rd,
  output logic [DATA_SZ-1:0] o_raddr,
  input  logic [DATA_SZ-1:0] i_alloc_addr,
  input  logic [DATA_SZ-1:0] i_rdata,
  input  logic               i_heap_err
);

  localparam logic [DATA_SZ-1:0] NIL        = DATA_SZ'(1);
  localparam logic [DATA_SZ-1:0] LOOP_LIMIT = DATA_SZ'(1) << ADDR_SZ;

  typedef enum logic [2:0] {
    S_IDLE, S_BUILD, S_BLAST, S_REL_RD, S_REL_FREE, S_DONE, S_FAULT
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_SZ-1:0] n_q, n_d;
  logic [DATA_SZ-1:0] cur_q, cur_d;
  logic [DATA_SZ-1:0] cnt_q, cnt_d;
  logic [DATA_SZ-1:0] result_q, result_d;
  logic               cur_ok;

`ifdef HEAP_CHAIN_CHECK_EN
  // Releasable pointers carry the MUT|VLT tag with DIR clear and no bits above the heap range.
  function automatic logic tag_ok(input logic [DATA_SZ-1:0] ptr);
    return (ptr[15:12] == 4'h5) && (ptr[11:ADDR_SZ] == '0);
  endfunction
  assign cur_ok = tag_ok(cur_q);
`else
  assign cur_ok = 1'b1;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      cur_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      cur_q    <= cur_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign o_result = result_q;

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    cur_d       = cur_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    o_cmd_ready = 1'b0;
    o_done      = 1'b0;
    o_fault     = 1'b0;
    o_alloc     = 1'b0;
    o_data      = '0;
    o_free      = 1'b0;
    o_addr      = '0;
    o_rd        = 1'b0;
    o_raddr     = '0;

    case (state_q)
      S_IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          cnt_d = '0;
          if (!i_cmd_op) begin
            n_d = i_cmd_arg;
            if (i_cmd_arg == '0) begin
              result_d = NIL;
              state_d  = S_DONE;
            end else begin
              state_d = S_BUILD;
            end
          end else begin
            cur_d = i_cmd_arg;
            if (i_cmd_arg == NIL) begin
              result_d = '0;
              state_d  = S_DONE;
            end else begin
              state_d = S_REL_RD;
            end
          end
        end
      end
      // Each new cell points at the one allocated the cycle before; the first is the tail.
      S_BUILD: begin
        o_alloc = 1'b1;
        o_data  = (cnt_q == '0) ? NIL : i_alloc_addr;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_d == n_q) state_d = S_BLAST;
      end
      S_BLAST: begin
        result_d = i_alloc_addr;
        state_d  = S_DONE;
      end
      S_REL_RD: begin
        if (!cur_ok) begin
          state_d = S_FAULT;
        end else begin
          o_rd    = 1'b1;
          o_raddr = cur_q;
          state_d = S_REL_FREE;
        end
      end
      // A count reaching the heap size can only come from a cyclic chain.
      S_REL_FREE: begin
        o_free = 1'b1;
        o_addr = cur_q;
        cur_d  = i_rdata;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_d == LOOP_LIMIT) begin
          state_d = S_FAULT;
        end else if (i_rdata == NIL) begin
          result_d = cnt_d;
          state_d  = S_DONE;
        end else begin
          state_d = S_REL_RD;
        end
      end
      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end
      S_FAULT: begin
        o_fault = 1'b1;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase

    if (i_heap_err && (state_q != S_IDLE) && (state_q != S_FAULT)) begin
      state_d = S_FAULT;
      o_done  = 1'b0;
    end
  end

endmodule

// File: tb/tb_heap_chain_ctl.sv
// Directed bench for heap_chain_ctl with a small behavioural allocator model.
// Expectations for the tag-check case follow HEAP_CHAIN_CHECK_EN.
module tb_heap_chain_ctl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_cmd_valid = 1'b0;
  logic        i_cmd_op = 1'b0;
  logic [15:0] i_cmd_arg = '0;
  logic        o_cmd_ready, o_done, o_fault;
  logic [15:0] o_result;
  logic        o_alloc, o_free, o_rd;
  logic [15:0] o_data, o_addr, o_raddr;
  logic [15:0] i_alloc_addr, i_rdata;
  logic        i_heap_err;

  heap_chain_ctl #(.DATA_SZ(16), .ADDR_SZ(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(i_cmd_valid), .i_cmd_op(i_cmd_op), .i_cmd_arg(i_cmd_arg),
    .o_cmd_ready(o_cmd_ready), .o_done(o_done), .o_result(o_result), .o_fault(o_fault),
    .o_alloc(o_alloc), .o_data(o_data),
    .o_free(o_free), .o_addr(o_addr),
    .o_rd(o_rd), .o_raddr(o_raddr),
    .i_alloc_addr(i_alloc_addr), .i_rdata(i_rdata), .i_heap_err(i_heap_err)
  );

  always #5 clk = ~clk;

  // Allocator model: address returned the cycle after alloc, data the cycle after rd.
  logic [15:0] mem [0:65535];
  logic [15:0] heap_base = 16'h50FD;
  logic [15:0] heap_limit = 16'hFFFF;
  logic [15:0] alloc_idx;
  logic        poke_en = 1'b0;
  logic [15:0] poke_addr = '0, poke_data = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      alloc_idx    <= '0;
      i_alloc_addr <= '0;
      i_rdata      <= '0;
      i_heap_err   <= 1'b0;
    end else begin
      i_heap_err <= 1'b0;
      if (poke_en) mem[poke_addr] <= poke_data;
      if (o_alloc) begin
        if ({1'b0, heap_base} + {1'b0, alloc_idx} > {1'b0, heap_limit}) begin
          i_heap_err <= 1'b1;
        end else begin
          mem[heap_base + alloc_idx] <= o_data;
          i_alloc_addr <= heap_base + alloc_idx;
          alloc_idx    <= alloc_idx + 16'd1;
        end
      end
      if (o_rd) i_rdata <= mem[o_raddr];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [15:0] q_alloc[$];
  logic [15:0] q_rd[$];
  logic [15:0] q_free[$];
  int          excl_viol;
  int          lat;
  logic [15:0] res;
  logic        busy_ready;
  logic        saw_done;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    poke_addr = a;
    poke_data = d;
    poke_en   = 1'b1;
    @(negedge clk);
    poke_en   = 1'b0;
  endtask

  // Issues one command and watches it to o_done or o_fault, logging every request strobe.
  task automatic run_cmd(input logic op, input logic [15:0] arg, input int budget,
                         input bit poke_busy);
    q_alloc.delete();
    q_rd.delete();
    q_free.delete();
    excl_viol = 0;
    lat = -1;
    res = '0;
    saw_done = 1'b0;
    busy_ready = 1'b1;
    @(negedge clk);
    i_cmd_valid = 1'b1;
    i_cmd_op    = op;
    i_cmd_arg   = arg;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) i_cmd_valid = 1'b0;
      if (o_alloc) q_alloc.push_back(o_data);
      if (o_rd)    q_rd.push_back(o_raddr);
      if (o_free)  q_free.push_back(o_addr);
      if ((int'(o_alloc) + int'(o_rd) + int'(o_free)) > 1) excl_viol++;
      if (o_done || o_fault) begin
        lat = k;
        res = o_result;
        saw_done = o_done;
        i_cmd_valid = 1'b0;
        break;
      end
      if (poke_busy && k == 2) begin
        i_cmd_valid = 1'b1;
        i_cmd_op    = 1'b0;
        i_cmd_arg   = 16'd5;
        busy_ready  = o_cmd_ready;
      end else if (poke_busy && k == 3) begin
        i_cmd_valid = 1'b0;
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_ready",  o_cmd_ready, 1);
    check_eq("rst_done",   o_done, 0);
    check_eq("rst_result", o_result, 16'h0000);
    check_eq("rst_fault",  o_fault, 0);
    check_eq("rst_strobes", {o_alloc, o_free, o_rd}, 3'b000);
    check_eq("rst_buses",  {o_data, o_addr, o_raddr}, 48'h0);

    // Build of three cells from a fresh heap starting at 0x50FD.
    run_cmd(1'b0, 16'd3, 50, 1'b0);
    check_eq("b3_lat",    lat, 5);
    check_eq("b3_result", res, 16'h50FF);
    check_eq("b3_nalloc", q_alloc.size(), 3);
    if (q_alloc.size() == 3) begin
      check_eq("b3_data0", q_alloc[0], 16'h0001);
      check_eq("b3_data1", q_alloc[1], 16'h50FD);
      check_eq("b3_data2", q_alloc[2], 16'h50FE);
    end
    check_eq("b3_excl", excl_viol, 0);
    @(negedge clk);
    check_eq("b3_ready_after", o_cmd_ready, 1);
    check_eq("b3_held", o_result, 16'h50FF);

    run_cmd(1'b0, 16'd0, 20, 1'b0);
    check_eq("b0_lat",    lat, 1);
    check_eq("b0_result", res, 16'h0001);
    check_eq("b0_nalloc", q_alloc.size(), 0);

    // Release the chain just built, with a stray command while busy.
    run_cmd(1'b1, 16'h50FF, 50, 1'b1);
    check_eq("r3_lat",    lat, 7);
    check_eq("r3_result", res, 16'd3);
    check_eq("r3_busy_ready", busy_ready, 0);
    check_eq("r3_nalloc", q_alloc.size(), 0);
    check_eq("r3_nrd",    q_rd.size(), 3);
    check_eq("r3_nfree",  q_free.size(), 3);
    if (q_free.size() == 3 && q_rd.size() == 3) begin
      check_eq("r3_free0", q_free[0], 16'h50FF);
      check_eq("r3_free1", q_free[1], 16'h50FE);
      check_eq("r3_free2", q_free[2], 16'h50FD);
      check_eq("r3_rd0",   q_rd[0],   16'h50FF);
      check_eq("r3_rd2",   q_rd[2],   16'h50FD);
    end
    check_eq("r3_excl", excl_viol, 0);
    repeat (3) @(negedge clk);
    check_eq("r3_ignored_idle", {o_cmd_ready, o_alloc, o_done}, 3'b100);

    run_cmd(1'b1, 16'h0001, 20, 1'b0);
    check_eq("rn_lat",    lat, 1);
    check_eq("rn_result", res, 16'd0);
    check_eq("rn_strobes", q_alloc.size() + q_rd.size() + q_free.size(), 0);

    // Untagged pointer: faults under tag checking, walks normally otherwise.
    poke(16'h8005, 16'h0001);
    run_cmd(1'b1, 16'h8005, 20, 1'b0);
`ifdef HEAP_CHAIN_CHECK_EN
    check_eq("tag_lat",   lat, 2);
    check_eq("tag_fault", o_fault, 1);
    check_eq("tag_nrd",   q_rd.size(), 0);
    check_eq("tag_nfree", q_free.size(), 0);
    check_eq("tag_nodone", saw_done, 0);
    do_reset();
`else
    check_eq("tag_lat",    lat, 3);
    check_eq("tag_result", res, 16'd1);
    check_eq("tag_nrd",    q_rd.size(), 1);
    if (q_rd.size() == 1) check_eq("tag_raddr", q_rd[0], 16'h8005);
    check_eq("tag_fault",  o_fault, 0);
`endif

    // Self-loop chain: frees 256 times, then faults.
    poke(16'h5010, 16'h5010);
    run_cmd(1'b1, 16'h5010, 700, 1'b0);
    check_eq("loop_lat",   lat, 513);
    check_eq("loop_fault", o_fault, 1);
    check_eq("loop_nfree", q_free.size(), 256);
    check_eq("loop_nodone", saw_done, 0);
    do_reset();

    // Build larger than the heap: allocator error forces a sticky fault.
    heap_base  = 16'h50FE;
    heap_limit = 16'h50FF;
    do_reset();
    run_cmd(1'b0, 16'd5, 50, 1'b0);
    check_eq("ovf_lat",    lat, 5);
    check_eq("ovf_fault",  o_fault, 1);
    check_eq("ovf_nodone", saw_done, 0);
    check_eq("ovf_nalloc", q_alloc.size(), 4);
    repeat (4) @(negedge clk);
    check_eq("ovf_sticky", {o_fault, o_cmd_ready, o_alloc, o_free, o_rd, o_done}, 6'b100000);
    rst = 1'b1;
    #1;
    check_eq("ovf_rst_fault", o_fault, 0);
    check_eq("ovf_rst_ready", o_cmd_ready, 1);
    check_eq("ovf_rst_result", o_result, 16'h0000);
    check_eq("ovf_rst_buses", {o_data, o_addr, o_raddr}, 48'h0);
    @(negedge clk);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
